// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: turns byte-addressed MIPS loads/stores into
// word accesses on a word-only data memory. Sub-word stores use
// read-modify-write. Load results are aligned and extended. The upstream
// pipeline is stalled while a multi-cycle access is in flight.
module mem_access_ctrl #(
    parameter int LITTLE_ENDIAN  = 1,
    parameter int MISALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Addr,
    output logic [31:0] Wdata,
    input  logic [31:0] Rdata,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        stall,
    output logic        misalign
);

    localparam logic [3:0] OP_LW  = 4'b0001;
    localparam logic [3:0] OP_LH  = 4'b0010;
    localparam logic [3:0] OP_LHU = 4'b0011;
    localparam logic [3:0] OP_LB  = 4'b0100;
    localparam logic [3:0] OP_LBU = 4'b0101;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_SH  = 4'b1010;
    localparam logic [3:0] OP_SB  = 4'b1100;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_WAIT = 3'd1,
        LOAD_RESP = 3'd2,
        RMW_WAIT  = 3'd3,
        RMW_WRITE = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] merge_r;
    logic        misaligned_s;
    logic        is_load_s;
    logic        is_rmw_s;

    // Physical byte slot inside the memory word for byte address offset a.
    function automatic logic [1:0] byte_slot(input logic [1:0] a);
        if (LITTLE_ENDIAN != 0) byte_slot = a;
        else                    byte_slot = 2'd3 - a;
    endfunction

    // Physical halfword slot; only addr[1] matters, addr[0] is ignored.
    function automatic logic half_slot(input logic a1);
        if (LITTLE_ENDIAN != 0) half_slot = a1;
        else                    half_slot = ~a1;
    endfunction

    function automatic logic [31:0] format_load(input logic [3:0]  op,
                                                input logic [1:0]  a,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{byte_slot(a), 3'b000} +: 8];
        h = word[{half_slot(a[1]), 4'b0000} +: 16];
        case (op)
            OP_LW:   format_load = word;
            OP_LH:   format_load = {{16{h[15]}}, h};
            OP_LHU:  format_load = {16'h0000, h};
            OP_LB:   format_load = {{24{b[7]}}, b};
            OP_LBU:  format_load = {24'h000000, b};
            default: format_load = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [3:0]  op,
                                                input logic [1:0]  a,
                                                input logic [31:0] word,
                                                input logic [31:0] data);
        logic [31:0] r;
        r = word;
        case (op)
            OP_SB:   r[{byte_slot(a), 3'b000} +: 8]      = data[7:0];
            OP_SH:   r[{half_slot(a[1]), 4'b0000} +: 16] = data[15:0];
            default: r = word;
        endcase
        merge_store = r;
    endfunction

    assign Addr = {2'b00, addr[31:2]};

    // Classify the incoming request.
    always_comb begin
        is_load_s = (mem_op == OP_LW) || (mem_op == OP_LH) || (mem_op == OP_LHU) ||
                    (mem_op == OP_LB) || (mem_op == OP_LBU);
        is_rmw_s  = (mem_op == OP_SH) || (mem_op == OP_SB);
        misaligned_s = 1'b0;
        if (MISALIGN_CHECK != 0) begin
            case (mem_op)
                OP_LW, OP_SW:         misaligned_s = (addr[1:0] != 2'b00);
                OP_LH, OP_LHU, OP_SH: misaligned_s = addr[0];
                default:              misaligned_s = 1'b0;
            endcase
        end else begin
            misaligned_s = 1'b0;
        end
    end

    // Next-state and strobe decode; reset forces every strobe low.
    always_comb begin
        state_next_s = state_r;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        Wdata        = store_data;
        stall        = 1'b0;
        misalign     = 1'b0;
        load_valid   = 1'b0;
        if (reset) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (misaligned_s) begin
                        misalign = 1'b1;
                    end else if (mem_op == OP_SW) begin
                        MemWrite = 1'b1;
                    end else if (is_load_s) begin
                        MemRead      = 1'b1;
                        stall        = 1'b1;
                        state_next_s = LOAD_WAIT;
                    end else if (is_rmw_s) begin
                        MemRead      = 1'b1;
                        stall        = 1'b1;
                        state_next_s = RMW_WAIT;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                LOAD_WAIT: begin
                    stall        = 1'b1;
                    state_next_s = LOAD_RESP;
                end
                LOAD_RESP: begin
                    load_valid   = 1'b1;
                    state_next_s = IDLE;
                end
                RMW_WAIT: begin
                    stall        = 1'b1;
                    state_next_s = RMW_WRITE;
                end
                RMW_WRITE: begin
                    MemWrite     = 1'b1;
                    Wdata        = merge_r;
                    state_next_s = IDLE;
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // State register plus the load-result and merge-word registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            load_data <= 32'h0000_0000;
            merge_r   <= 32'h0000_0000;
        end else begin
            state_r <= state_next_s;
            if (state_r == LOAD_WAIT) begin
                load_data <= format_load(mem_op, addr[1:0], Rdata);
            end
            if (state_r == RMW_WAIT) begin
                merge_r <= merge_store(mem_op, addr[1:0], Rdata, store_data);
            end
        end
    end

endmodule
